// File: rtl/banco_registros_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the WB stage, the ID stage and the register file.
package pkg_mips;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/banco_registros_if.sv
// Write-back and read-port bundle of the register file.
// master: WB/ID side, slave: banco_registros.
interface banco_registros_if;
  import pkg_mips::*;

  logic     reg_write_in;
  reg_idx_t rd_in;
  word_t    dato_escribir_in;
  reg_idx_t rs_addr;
  reg_idx_t rt_addr;
  word_t    rs_data;
  word_t    rt_data;
  logic     escritura_valida;

  modport master (
    output reg_write_in, rd_in, dato_escribir_in,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, escritura_valida
  );

  modport slave (
    input  reg_write_in, rd_in, dato_escribir_in,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, escritura_valida
  );

endinterface

// File: rtl/banco_registros_puerto_lectura.sv
// One combinational read port: $zero check, reset gate
// and the WB->ID write-through bypass mux.
module puerto_lectura #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_eff,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data
);

  // stored value, overridden by bypass, forced 0 by $zero/reset
  always_comb begin
    data = stored;
    if (BYPASS_EN != 0 && wr_eff && rd == addr)
      data = wdata;
    if (!rst_n || addr == '0)
      data = '0;
  end

endmodule

// File: rtl/banco_registros.sv
// MIPS 32x32 register file, two read ports, one write port.
// Optional BANCO_REGISTROS_CONTADOR_EN adds num_escrituras.
module banco_registros #(
  parameter int DATA_W    = pkg_mips::DATA_W,
  parameter int NUM_REGS  = pkg_mips::NUM_REGS,
  parameter int ADDR_W    = pkg_mips::ADDR_W,
  parameter int BYPASS_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  banco_registros_if.slave   bus
`ifdef BANCO_REGISTROS_CONTADOR_EN
  ,
  output logic [31:0]        num_escrituras
`endif
);
  import pkg_mips::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_eff;

  assign wr_eff = bus.reg_write_in &&
                  (bus.rd_in != REG_ZERO);

  // register array; entry 0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_eff) begin
      regs[bus.rd_in] <= bus.dato_escribir_in;
    end
  end

  // flags an effective write on the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.escritura_valida <= 1'b0;
    else
      bus.escritura_valida <= wr_eff;
  end

`ifdef BANCO_REGISTROS_CONTADOR_EN
  logic [31:0] contador;

  // saturating count of effective writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      contador <= '0;
    else if (wr_eff && contador != 32'hFFFF_FFFF)
      contador <= contador + 32'd1;
  end

  assign num_escrituras = contador;
`endif

  puerto_lectura #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_rs (
    .rst_n  (rst_n),
    .addr   (bus.rs_addr),
    .stored (regs[bus.rs_addr]),
    .wr_eff (wr_eff),
    .rd     (bus.rd_in),
    .wdata  (bus.dato_escribir_in),
    .data   (bus.rs_data)
  );

  puerto_lectura #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_rt (
    .rst_n  (rst_n),
    .addr   (bus.rt_addr),
    .stored (regs[bus.rt_addr]),
    .wr_eff (wr_eff),
    .rd     (bus.rd_in),
    .wdata  (bus.dato_escribir_in),
    .data   (bus.rt_data)
  );

endmodule
